snake_engine: RTL

//  Next-generation snake body engine. Keeps the body in a MAX_LEN-deep ring buffer (head pointer plus length), so a move

---
 rtl/snake_if.sv | 36 +++
 rtl/snake_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/snake_if.sv
// Handshake and renderer bus between the game FSM / renderer and snake_engine.
interface snake_if #(
    parameter int H       = 32,
    parameter int V       = 32,
    parameter int MAX_LEN = 64
);
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic [1:0]    dir;
    logic          step;
    logic          grow;
    logic          busy;
    logic          done;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] len;
    logic          full;
    logic          self_col;
    logic          wall_col;
    logic [AW-1:0] rd_idx;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_valid;

    modport master (
        output dir, step, grow, rd_idx,
        input  busy, done, head_x, head_y, len, full, self_col, wall_col, rd_x, rd_y, rd_valid
    );
    modport slave (
        input  dir, step, grow, rd_idx,
        output busy, done, head_x, head_y, len, full, self_col, wall_col, rd_x, rd_y, rd_valid
    );
endinterface

// File: rtl/snake_engine.sv
// Snake body engine: ring buffer (head pointer + length), serial self-collision scan, and an
// independent registered read port for the renderer.
module snake_engine #(
    parameter int H        = 32,
    parameter int V        = 32,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter bit WRAP     = 1'b1
) (
    input logic    clk,
    input logic    reset,
    snake_if.slave bus
);
    localparam int XW  = $clog2(H);
    localparam int YW  = $clog2(V);
    localparam int AW  = $clog2(MAX_LEN);
    localparam int LW  = $clog2(MAX_LEN + 1);
    localparam int AW1 = AW + 1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_SCAN, S_COMMIT} state_e;

    function automatic logic [AW-1:0] ring_inc(input logic [AW-1:0] a);
        return (a == AW'(MAX_LEN - 1)) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [AW-1:0] ring_dec(input logic [AW-1:0] a);
        return (a == '0) ? AW'(MAX_LEN - 1) : a - AW'(1);
    endfunction

    logic [XW-1:0] mem_x [MAX_LEN];
    logic [YW-1:0] mem_y [MAX_LEN];

    state_e        state_q;
    logic [AW-1:0] hp_q, scan_addr_q, init_addr_q;
    logic [LW-1:0] len_q, scan_cnt_q, scan_n_q, init_cnt_q;
    logic [XW-1:0] head_x_q, nx_q, init_x_q, rd_x_q;
    logic [YW-1:0] head_y_q, ny_q, rd_y_q;
    logic [1:0]    heading_q, ndir_q;
    logic          grow_q, commit_q, done_q, self_col_q, wall_col_q, rd_valid_q;

    logic          full;
    logic [1:0]    dir_d;
    logic [XW-1:0] nx_d, wx;
    logic [YW-1:0] ny_d, wy;
    logic          oob_d, we, hit, rvalid_d;
    logic [AW-1:0] waddr, raddr_d;

    assign full = (len_q == LW'(MAX_LEN));
    assign hit  = (mem_x[scan_addr_q] == nx_q) && (mem_y[scan_addr_q] == ny_q);

    // A request to reverse onto the neck keeps the current heading.
    always_comb begin
        dir_d = (bus.dir == (heading_q ^ 2'd2)) ? heading_q : bus.dir;
        nx_d  = head_x_q;
        ny_d  = head_y_q;
        oob_d = 1'b0;
        case (dir_d)
            2'd0: if (head_x_q == XW'(H - 1)) begin nx_d = '0; oob_d = ~WRAP; end
                  else nx_d = head_x_q + XW'(1);
            2'd1: if (head_y_q == YW'(V - 1)) begin ny_d = '0; oob_d = ~WRAP; end
                  else ny_d = head_y_q + YW'(1);
            2'd2: if (head_x_q == '0) begin nx_d = XW'(H - 1); oob_d = ~WRAP; end
                  else nx_d = head_x_q - XW'(1);
            default: if (head_y_q == '0) begin ny_d = YW'(V - 1); oob_d = ~WRAP; end
                  else ny_d = head_y_q - YW'(1);
        endcase
    end

    always_comb begin
        we    = 1'b0;
        waddr = init_addr_q;
        wx    = init_x_q;
        wy    = YW'(V / 2);
        if (!reset && state_q == S_INIT) begin
            we = 1'b1;
        end else if (!reset && state_q == S_COMMIT && commit_q) begin
            we    = 1'b1;
            waddr = ring_inc(hp_q);
            wx    = nx_q;
            wy    = ny_q;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_x[waddr] <= wx;
            mem_y[waddr] <= wy;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            hp_q        <= '0;
            len_q       <= LW'(INIT_LEN);
            head_x_q    <= XW'(H / 2);
            head_y_q    <= YW'(V / 2);
            heading_q   <= 2'd0;
            nx_q        <= '0;
            ny_q        <= '0;
            ndir_q      <= 2'd0;
            grow_q      <= 1'b0;
            commit_q    <= 1'b0;
            scan_cnt_q  <= '0;
            scan_n_q    <= '0;
            scan_addr_q <= '0;
            done_q      <= 1'b0;
            self_col_q  <= 1'b0;
            wall_col_q  <= 1'b0;
            init_cnt_q  <= '0;
            init_addr_q <= '0;
            init_x_q    <= XW'(H / 2);
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    init_cnt_q  <= init_cnt_q + LW'(1);
                    init_addr_q <= ring_dec(init_addr_q);
                    init_x_q    <= init_x_q - XW'(1);
                    if (init_cnt_q == LW'(INIT_LEN - 1)) state_q <= S_IDLE;
                end
                S_IDLE: if (bus.step) begin
                    if (self_col_q || wall_col_q) begin
                        done_q <= 1'b1;
                    end else begin
                        nx_q        <= nx_d;
                        ny_q        <= ny_d;
                        ndir_q      <= dir_d;
                        grow_q      <= bus.grow & ~full;
                        scan_cnt_q  <= '0;
                        scan_addr_q <= hp_q;
                        // The tail cell vacates unless the snake grows this move.
                        scan_n_q    <= (bus.grow && !full) ? len_q : len_q - LW'(1);
                        commit_q    <= ~oob_d;
                        wall_col_q  <= oob_d;
                        state_q     <= oob_d ? S_COMMIT : S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        self_col_q <= 1'b1;
                        commit_q   <= 1'b0;
                        state_q    <= S_COMMIT;
                    end else if (scan_cnt_q == scan_n_q - LW'(1)) begin
                        state_q <= S_COMMIT;
                    end else begin
                        scan_cnt_q  <= scan_cnt_q + LW'(1);
                        scan_addr_q <= ring_dec(scan_addr_q);
                    end
                end
                default: begin
                    if (commit_q) begin
                        hp_q      <= ring_inc(hp_q);
                        head_x_q  <= nx_q;
                        head_y_q  <= ny_q;
                        heading_q <= ndir_q;
                        len_q     <= len_q + LW'(grow_q);
                    end
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Segment i lives at (hp - i) mod MAX_LEN; explicit wrap keeps non-power-of-two depths correct.
    always_comb begin
        rvalid_d = (LW'(bus.rd_idx) < len_q);
        raddr_d  = '0;
        if (rvalid_d) begin
            if (hp_q >= bus.rd_idx) raddr_d = hp_q - bus.rd_idx;
            else raddr_d = AW'(AW1'(hp_q) + AW1'(MAX_LEN) - AW1'(bus.rd_idx));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rvalid_d;
            rd_x_q     <= rvalid_d ? mem_x[raddr_d] : '0;
            rd_y_q     <= rvalid_d ? mem_y[raddr_d] : '0;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.head_x   = head_x_q;
    assign bus.head_y   = head_y_q;
    assign bus.len      = len_q;
    assign bus.full     = full;
    assign bus.self_col = self_col_q;
    assign bus.wall_col = wall_col_q;
    assign bus.rd_x     = rd_x_q;
    assign bus.rd_y     = rd_y_q;
    assign bus.rd_valid = rd_valid_q;
endmodule
